// File: rtl/o_ddr_gearbox_pkg.sv
// Shared types and constants for the parallel-to-DDR output gearbox.
package o_ddr_gearbox_pkg;

   typedef enum logic [0:0] {
      GB_IDLE = 1'b0,
      GB_RUN  = 1'b1
   } gb_state_t;

   localparam logic [1:0] IDLE_PAT_DEFAULT = 2'b00;

   // Beat counter width for a word of the given bit width (two bits per beat).
   function automatic int unsigned beat_cnt_width(input int unsigned width);
      return (width / 2 > 1) ? $clog2(width / 2) : 1;
   endfunction

endpackage

// File: rtl/o_ddr_gearbox_shifter.sv
// Loadable pair shifter: presents one 2-bit pair per beat directly from its register,
// back-filling with the idle pair so an exhausted word leaves the idle pattern on pair.
module o_ddr_gearbox_shifter
   import o_ddr_gearbox_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1,
   parameter logic [1:0]  IDLE_PAT  = IDLE_PAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic [1:0]       pair,
   output logic             last
);

   localparam int unsigned N  = WIDTH / 2;
   localparam int unsigned CW = beat_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
   // Fill pair laid out so that the output tap reads IDLE_PAT in either bit order.
   localparam logic [1:0] FILL = LSB_FIRST ? IDLE_PAT : {IDLE_PAT[0], IDLE_PAT[1]};
   localparam logic [WIDTH-1:0] IDLE_WORD = {N{FILL}};

   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= IDLE_WORD;
         cnt  <= '0;
      end else if (load) begin
         sreg <= data;
         cnt  <= '0;
      end else if (shift) begin
         if (LSB_FIRST) sreg <= {FILL, sreg[WIDTH-1:2]};
         else           sreg <= {sreg[WIDTH-3:0], FILL};
         cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
      end
   end

   assign pair = LSB_FIRST ? sreg[1:0] : {sreg[WIDTH-2], sreg[WIDTH-1]};
   assign last = (cnt == LAST_BEAT);

endmodule

// File: rtl/o_ddr_gearbox.sv
// Parallel-to-DDR gearbox: one-word hold slot behind a pair shifter, streaming
// gaplessly to the DDR output register and pulsing UF when the stream runs dry.
module o_ddr_gearbox
   import o_ddr_gearbox_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1,
   parameter logic [1:0]  IDLE_PAT  = IDLE_PAT_DEFAULT
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   output logic             DR,
   output logic [1:0]       Q,
   output logic             QE,
   output logic             UF
);

   gb_state_t        state, state_nx;
   logic [WIDTH-1:0] hold;
   logic             hold_full, hold_full_nx;
   logic             accept_c, load_c, shift_c, last, qe_nx, uf_nx;

   assign accept_c = DV && DR;

   always_ff @(posedge C or posedge R) begin
      if (R) state <= GB_IDLE;
      else   state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load_c   = 1'b0;
      shift_c  = 1'b0;
      uf_nx    = 1'b0;
      case (state)
         GB_IDLE: begin
            if (hold_full) begin
               load_c   = 1'b1;
               state_nx = GB_RUN;
            end
         end
         GB_RUN: begin
            if (!last) begin
               shift_c = 1'b1;
            end else if (hold_full) begin
               load_c = 1'b1;
            end else begin
               // Final shift drains the word, leaving the idle pattern on Q.
               shift_c  = 1'b1;
               uf_nx    = 1'b1;
               state_nx = GB_IDLE;
            end
         end
         default: state_nx = GB_IDLE;
      endcase
      hold_full_nx = accept_c || (hold_full && !load_c);
      qe_nx        = (state_nx == GB_RUN);
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         hold      <= '0;
         hold_full <= 1'b0;
         DR        <= 1'b0;
         QE        <= 1'b0;
         UF        <= 1'b0;
      end else begin
         if (accept_c) hold <= D;
         hold_full <= hold_full_nx;
         DR        <= !hold_full_nx;
         QE        <= qe_nx;
         UF        <= uf_nx;
      end
   end

   o_ddr_gearbox_shifter #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST),
      .IDLE_PAT  (IDLE_PAT)
   ) u_shifter (
      .clk   (C),
      .rst   (R),
      .load  (load_c),
      .shift (shift_c),
      .data  (hold),
      .pair  (Q),
      .last  (last)
   );

endmodule

// File: tb/tb_o_ddr_gearbox.sv
// Directed bench for o_ddr_gearbox: LSB-first and MSB-first instances, hand-computed pairs.
module tb_o_ddr_gearbox;

   logic       C;
   logic       R;
   logic [7:0] D, Dm;
   logic       DV, DVm;
   logic       DR, DRm;
   logic [1:0] Q, Qm;
   logic       QE, QEm;
   logic       UF, UFm;

   int vectors = 0;
   int errors  = 0;

   o_ddr_gearbox #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_PAT(2'b00)) dut_lsb (
      .C(C), .R(R), .D(D), .DV(DV), .DR(DR), .Q(Q), .QE(QE), .UF(UF)
   );

   o_ddr_gearbox #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_PAT(2'b00)) dut_msb (
      .C(C), .R(R), .D(Dm), .DV(DVm), .DR(DRm), .Q(Qm), .QE(QEm), .UF(UFm)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic step();
      @(posedge C);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [1:0] seq2 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [1:0] seq3 [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
   logic [1:0] seq4 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [1:0] seq5 [8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};

   initial begin
      R = 1'b1; D = 8'h00; DV = 1'b0; Dm = 8'h00; DVm = 1'b0;

      // 1: reset state and release
      step(); step();
      check("rst_dr", DR, 0); check("rst_q", Q, 0); check("rst_qe", QE, 0); check("rst_uf", UF, 0);
      @(negedge C) R = 1'b0;
      step();
      check("rel_dr", DR, 1); check("rel_dr_msb", DRm, 1);
      for (int i = 0; i < 10; i++) begin
         check("idle_q", Q, 0); check("idle_qe", QE, 0); check("idle_uf", UF, 0);
         step();
      end

      // 2: single word B4, LSB first
      D = 8'hB4; DV = 1'b1;
      step();
      DV = 1'b0;
      check("t2_dr_after_acc", DR, 0); check("t2_qe_latency", QE, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_q", Q, seq2[i]); check("t2_qe", QE, 1); check("t2_uf", UF, 0);
      end
      step();
      check("t2_end_q", Q, 0); check("t2_end_qe", QE, 0); check("t2_end_uf", UF, 1);
      step();
      check("t2_uf_once", UF, 0);

      // 3: back-to-back B4 then 1E
      D = 8'hB4; DV = 1'b1;
      step();
      D = 8'h1E;
      step();
      check("t3_q0", Q, seq3[0]); check("t3_dr_free", DR, 1);
      step();
      DV = 1'b0;
      check("t3_q1", Q, seq3[1]); check("t3_dr_full", DR, 0);
      for (int i = 2; i < 8; i++) begin
         step();
         check("t3_q", Q, seq3[i]); check("t3_qe", QE, 1); check("t3_uf", UF, 0);
      end
      step();
      check("t3_end_qe", QE, 0); check("t3_end_uf", UF, 1); check("t3_end_q", Q, 0);

      // 5: backpressure, D changes while DR=0 must not be captured
      step();
      D = 8'h4B; DV = 1'b1;
      step();
      check("t5_dr0", DR, 0);
      D = 8'hD2;
      step();
      check("t5_dr1", DR, 1); check("t5_q0", Q, seq5[0]);
      step();
      D = 8'hFF;
      check("t5_dr2", DR, 0); check("t5_q1", Q, seq5[1]);
      step();
      D = 8'h00;
      check("t5_dr3", DR, 0); check("t5_q2", Q, seq5[2]);
      step();
      check("t5_dr4", DR, 0); check("t5_q3", Q, seq5[3]);
      step();
      DV = 1'b0;
      check("t5_dr5", DR, 1); check("t5_q4", Q, seq5[4]); check("t5_qe4", QE, 1);
      for (int i = 5; i < 8; i++) begin
         step();
         check("t5_q", Q, seq5[i]); check("t5_qe", QE, 1); check("t5_uf", UF, 0);
      end
      step();
      check("t5_end_qe", QE, 0); check("t5_end_uf", UF, 1);

      // 4: MSB-first instance, B4
      Dm = 8'hB4; DVm = 1'b1;
      step();
      DVm = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_q", Qm, seq4[i]); check("t4_qe", QEm, 1);
      end
      step();
      check("t4_end_q", Qm, 0); check("t4_end_qe", QEm, 0); check("t4_end_uf", UFm, 1);

      // 6: async reset between edges during beat 2
      step();
      D = 8'hB4; DV = 1'b1;
      step();
      DV = 1'b0;
      step(); step(); step();
      check("t6_beat2", Q, 2'b11);
      #2 R = 1'b1;
      #1;
      check("t6_rst_q", Q, 0); check("t6_rst_qe", QE, 0); check("t6_rst_dr", DR, 0); check("t6_rst_uf", UF, 0);
      @(negedge C) R = 1'b0;
      step();
      check("t6_rel_dr", DR, 1);
      for (int i = 0; i < 6; i++) begin
         check("t6_q", Q, 0); check("t6_qe", QE, 0); check("t6_uf", UF, 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/o_ddr_gearbox.md
Name: o_ddr_gearbox

Overview:
Parallel-to-DDR gearbox that sits directly upstream of the DDR output register. It accepts WIDTH-bit words from fabric logic over a valid/ready handshake. Each word is emitted as a stream of 2-bit pairs, one pair per clock, on Q/QE, which drive the DDR register's D[1:0]/E inputs. A one-word holding slot plus the active shifter allows gapless streaming and flags underruns.

Parameters:
WIDTH, 8, parallel word width; even, 4..32; beats per word N = WIDTH/2
LSB_FIRST, 1, 1: word bit 0 leaves first in time; 0: bit WIDTH-1 leaves first
IDLE_PAT, 2'b00, pair driven on Q while no data is being streamed

Ports:
C  input  1  clock; shared with the downstream DDR register
R  input  1  reset; asynchronous, active-high
D  input  WIDTH  parallel data word
DV  input  1  data valid
DR  output  1  data ready; transfer occurs on posedge C when DV && DR
Q  output  2  pair to downstream D[1:0]; Q[0] = rising-half bit, Q[1] = falling-half bit
QE  output  1  pair enable to downstream E; 1 while Q carries word data
UF  output  1  underrun pulse; one cycle

Behaviour:
- Reset (R=1, async): Q=IDLE_PAT, QE=0, DR=0, UF=0, hold slot empty, shifter idle, beat counter 0. In-flight and held words are discarded. No UF pulse on reset entry or exit.
- DR is registered. It rises on the first posedge after R deasserts. At every edge, DR is set to 1 iff the hold slot is empty after that edge.
- Accept: DV && DR at edge k writes D into the hold slot. DV while DR=0 is ignored; the source holds D/DV until accepted.
- State machine: GB_IDLE, GB_RUN.
- GB_IDLE with hold full: load the shifter from hold and go to GB_RUN. The first pair of the word appears on Q, with QE=1, after edge k+1 (two-edge latency from acceptance to first pair).
- GB_RUN: one pair per edge; beat counter counts 0..N-1.
- On the edge after beat N-1 (i.e. the last pair of a word has been shown):
  - hold full: load the next word, beat counter to 0, stay in GB_RUN. No gap, QE stays 1.
  - hold empty: Q=IDLE_PAT, QE=0, UF=1 for exactly that cycle, go to GB_IDLE.
- Simultaneous accept and load-from-hold on the same edge is legal: the new word lands in the freed slot, and DR stays 1 only if the slot ends empty.
- Pair ordering, beat b (0..N-1):
  - LSB_FIRST=1: Q[0]=D[2b], Q[1]=D[2b+1].
  - LSB_FIRST=0: Q[0]=D[WIDTH-1-2b], Q[1]=D[WIDTH-2-2b].
- Q, QE and UF are registered outputs with no combinational path from D/DV.
- Reset mid-word: Q returns to IDLE_PAT and QE to 0 immediately, with no partial-word completion.

Decomposition:
- Package o_ddr_gearbox_pkg holds:
  - state enum gb_state_t {GB_IDLE, GB_RUN}
  - a beat-counter width function clog2(WIDTH/2)
  - the default IDLE_PAT constant
- One natural sub-module, o_ddr_gearbox_shifter: loadable WIDTH-bit shift register plus beat counter, with outputs pair[1:0] and last.
- The top level owns the hold slot, the handshake, the FSM and UF.

Test Plan:
1. Reset release (WIDTH=8), DV=0: DR goes 0 to 1 on the first edge after R falls. Q=2'b00, QE=0 and UF=0 held for 10 cycles.
2. Single word D=8'hB4, LSB_FIRST=1, accepted at edge k: after edges k+1..k+4, Q={Q[1],Q[0]} = 00, 01, 11, 10 with QE=1. After edge k+5, Q=00, QE=0 and UF=1 for one cycle.
3. Back-to-back 8'hB4 then 8'h1E, DV held high: eight consecutive pairs 00,01,11,10,10,11,01,00 with QE never dropping. DR toggles so that the second word is accepted while the first is streaming. UF fires only after the eighth pair.
4. LSB_FIRST=0, D=8'hB4: Q sequence 01, 11, 10, 00 (bit 7 first on Q[0]).
5. Backpressure: DV held high with a new word queued behind a held word gives DR=0 until the shifter loads. D changed while DR=0 is not captured; the streamed data matches only the accepted words.
6. Async reset asserted between clock edges during beat 2 of 8'hB4: Q=IDLE_PAT, QE=0 and DR=0 immediately. After release, no residual pairs appear and UF stays 0.
